// File: rtl/miso_phase_calibrator.sv
// Purpose : sweeps the MISO sampling phase, test-reads a known word at each lag, and
//           parks phase_select in the middle of the longest run of passing phases.
// Latency : one calibration takes about NUM_PHASES*(SETTLE + TRIALS*(handshake+reply+2))
//           cycles plus NUM_PHASES search cycles. done pulses once, in the FINISH cycle.
// Backpr. : cmd_req is held until cmd_ack. A missing rx_valid is bounded by TIMEOUT_CYCLES.
// Ports   : i_dataclk/i_reset       clock, synchronous active-high reset
//           i_start                 begin a calibration (accepted in IDLE only)
//           i_phase_wr/i_phase_in   manual phase load in IDLE, clamped to NUM_PHASES-1
//           o_cmd_req/i_cmd_ack     read request handshake with the SPI sequencer
//           i_rx_valid/i_rx_word    returned MISO word from the phase selector
//           o_phase_select          current phase lag
//           o_busy/o_done           activity flag and end-of-calibration pulse
//           o_pass_map/o_best_phase/o_cal_ok  results; these hold until the next start
module miso_phase_calibrator #(
   parameter int          NUM_PHASES     = 12,
   parameter int          TRIALS         = 4,
   parameter logic [15:0] EXPECTED_WORD  = 16'h0049,
   parameter int          SETTLE_CYCLES  = 8,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                  i_dataclk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_phase_wr,
   input  logic [3:0]            i_phase_in,
   output logic                  o_cmd_req,
   input  logic                  i_cmd_ack,
   input  logic                  i_rx_valid,
   input  logic [15:0]           i_rx_word,
   output logic [3:0]            o_phase_select,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [NUM_PHASES-1:0] o_pass_map,
   output logic [3:0]            o_best_phase,
   output logic                  o_cal_ok
);

   localparam int         SW         = $clog2(SETTLE_CYCLES + 1);
   localparam int         TW         = $clog2(TRIALS + 1);
   localparam int         OW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam int         LW         = $clog2(NUM_PHASES + 1);
   localparam logic [3:0] LAST_PHASE = 4'(NUM_PHASES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_REQ,
      S_WAIT,
      S_EVAL,
      S_SEARCH,
      S_FINISH
   } state_t;

   state_t                r_state;
   logic [3:0]            r_phase_select;
   logic [3:0]            r_saved_phase;
   logic [NUM_PHASES-1:0] r_pass_map;
   logic [3:0]            r_best_phase;
   logic                  r_cal_ok;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_cmd_req;
   logic                  r_match;
   logic [SW-1:0]         r_settle_cnt;
   logic [TW-1:0]         r_trial_cnt;
   logic [OW-1:0]         r_timeout_cnt;
   logic [3:0]            r_search_idx;
   logic [3:0]            r_cur_start;
   logic [LW-1:0]         r_cur_len;
   logic [3:0]            r_best_start;
   logic [LW-1:0]         r_best_len;

   logic                  w_bit;
   logic [LW-1:0]         w_run_len;
   logic [3:0]            w_run_start;
   logic [LW-1:0]         w_fin_len;
   logic [3:0]            w_fin_start;
   logic [LW-1:0]         w_half;
   logic [3:0]            w_best;
   logic [TW-1:0]         w_trial_next;

   // Run tracking for the current search step, including the bit being scanned,
   // so the final cycle can produce the result without an extra pipeline stage.
   // A strictly longer run replaces the best one, which keeps the lowest start on ties.
   always_comb begin
      w_bit        = r_pass_map[r_search_idx];
      w_run_len    = w_bit ? (r_cur_len + LW'(1)) : '0;
      w_run_start  = (r_cur_len == '0) ? r_search_idx : r_cur_start;
      w_fin_len    = r_best_len;
      w_fin_start  = r_best_start;
      if (w_bit && (w_run_len > r_best_len)) begin
         w_fin_len   = w_run_len;
         w_fin_start = w_run_start;
      end
      w_half       = (w_fin_len - LW'(1)) >> 1;
      w_best       = w_fin_start + 4'(w_half);
      w_trial_next = r_trial_cnt + TW'(1);
   end

   always_ff @(posedge i_dataclk) begin
      if (i_reset) begin
         r_state        <= S_IDLE;
         r_phase_select <= '0;
         r_saved_phase  <= '0;
         r_pass_map     <= '0;
         r_best_phase   <= '0;
         r_cal_ok       <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_cmd_req      <= 1'b0;
         r_match        <= 1'b0;
         r_settle_cnt   <= '0;
         r_trial_cnt    <= '0;
         r_timeout_cnt  <= '0;
         r_search_idx   <= '0;
         r_cur_start    <= '0;
         r_cur_len      <= '0;
         r_best_start   <= '0;
         r_best_len     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_saved_phase  <= r_phase_select;
                  r_pass_map     <= '0;
                  r_phase_select <= '0;
                  r_trial_cnt    <= '0;
                  r_settle_cnt   <= '0;
                  r_busy         <= 1'b1;
                  r_state        <= S_SETTLE;
               end else if (i_phase_wr) begin
                  r_phase_select <= (i_phase_in > LAST_PHASE) ? LAST_PHASE : i_phase_in;
               end
            end

            S_SETTLE: begin
               if (r_settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                  r_settle_cnt <= '0;
                  r_cmd_req    <= 1'b1;
                  r_state      <= S_REQ;
               end else begin
                  r_settle_cnt <= r_settle_cnt + SW'(1);
               end
            end

            S_REQ: begin
               if (i_cmd_ack) begin
                  r_cmd_req     <= 1'b0;
                  r_timeout_cnt <= '0;
                  r_state       <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (i_rx_valid) begin
                  r_match <= (i_rx_word == EXPECTED_WORD);
                  r_state <= S_EVAL;
               end else if (r_timeout_cnt == OW'(TIMEOUT_CYCLES - 1)) begin
                  r_match <= 1'b0;
                  r_state <= S_EVAL;
               end else begin
                  r_timeout_cnt <= r_timeout_cnt + OW'(1);
               end
            end

            S_EVAL: begin
               if (r_match && (w_trial_next < TW'(TRIALS))) begin
                  // Further trials at the same phase go straight back to REQ; the
                  // selector has not moved, so no settling is needed.
                  r_trial_cnt <= w_trial_next;
                  r_cmd_req   <= 1'b1;
                  r_state     <= S_REQ;
               end else begin
                  // Either the last trial matched or any trial missed: phase is done.
                  if (r_match) begin
                     r_pass_map[r_phase_select] <= 1'b1;
                  end
                  r_trial_cnt <= '0;
                  if (r_phase_select < LAST_PHASE) begin
                     r_phase_select <= r_phase_select + 4'd1;
                     r_settle_cnt   <= '0;
                     r_state        <= S_SETTLE;
                  end else begin
                     r_search_idx <= '0;
                     r_cur_start  <= '0;
                     r_cur_len    <= '0;
                     r_best_start <= '0;
                     r_best_len   <= '0;
                     r_state      <= S_SEARCH;
                  end
               end
            end

            S_SEARCH: begin
               r_cur_len    <= w_run_len;
               r_cur_start  <= w_run_start;
               r_best_len   <= w_fin_len;
               r_best_start <= w_fin_start;
               if (r_search_idx == LAST_PHASE) begin
                  // Results are registered on entry to FINISH so that they are
                  // already valid in the cycle where done is high.
                  if (w_fin_len != '0) begin
                     r_cal_ok       <= 1'b1;
                     r_best_phase   <= w_best;
                     r_phase_select <= w_best;
                  end else begin
                     r_cal_ok       <= 1'b0;
                     r_best_phase   <= '0;
                     r_phase_select <= r_saved_phase;
                  end
                  r_done  <= 1'b1;
                  r_state <= S_FINISH;
               end else begin
                  r_search_idx <= r_search_idx + 4'd1;
               end
            end

            S_FINISH: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_cmd_req      = r_cmd_req;
   assign o_phase_select = r_phase_select;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_pass_map     = r_pass_map;
   assign o_best_phase   = r_best_phase;
   assign o_cal_ok       = r_cal_ok;

endmodule

// File: tb/tb_miso_phase_calibrator.sv
// Purpose : self-checking bench for miso_phase_calibrator with a randomized sequencer model.
// Latency : not applicable (bench).
// Backpr. : the sequencer model delays cmd_ack and rx_valid randomly.
module tb_miso_phase_calibrator;

   localparam int          NP  = 12;
   localparam int          TR  = 4;
   localparam logic [15:0] EXP = 16'h0049;
   localparam int          SC  = 8;
   localparam int          TO  = 255;

   logic          i_dataclk;
   logic          i_reset;
   logic          i_start;
   logic          i_phase_wr;
   logic [3:0]    i_phase_in;
   logic          o_cmd_req;
   logic          i_cmd_ack;
   logic          i_rx_valid;
   logic [15:0]   i_rx_word;
   logic [3:0]    o_phase_select;
   logic          o_busy;
   logic          o_done;
   logic [NP-1:0] o_pass_map;
   logic [3:0]    o_best_phase;
   logic          o_cal_ok;

   miso_phase_calibrator #(
      .NUM_PHASES(NP), .TRIALS(TR), .EXPECTED_WORD(EXP),
      .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_dataclk(i_dataclk), .i_reset(i_reset), .i_start(i_start),
      .i_phase_wr(i_phase_wr), .i_phase_in(i_phase_in),
      .o_cmd_req(o_cmd_req), .i_cmd_ack(i_cmd_ack),
      .i_rx_valid(i_rx_valid), .i_rx_word(i_rx_word),
      .o_phase_select(o_phase_select), .o_busy(o_busy), .o_done(o_done),
      .o_pass_map(o_pass_map), .o_best_phase(o_best_phase), .o_cal_ok(o_cal_ok)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Sequencer model configuration for the current run.
   logic [NP-1:0] good_mask   = '0;
   int            no_rx_phase = -1;
   int            late_phase  = -1;
   int            fixed_hold  = 0;
   int            fail_trial[16];

   // Observations made by the sequencer model and the monitor.
   int req_count[16];
   int gap[16];
   int hs_cyc[16];
   int req_hi[16];
   int chg_cyc[16];
   int proto_err = 0;
   int cyc = 0;
   int mark = 0;

   // Expectations for the current run.
   int exp_bp;
   bit exp_ok;
   int exp_ps;
   int pe0;

   initial begin
      i_dataclk = 1'b0;
      forever #5 i_dataclk = ~i_dataclk;
   end

   // Monitor: cycle counter, and the cycle of the last event that should start a settle period.
   initial begin
      logic [3:0] prev_ps;
      logic       prev_busy;
      prev_ps   = '0;
      prev_busy = 1'b0;
      forever begin
         @(posedge i_dataclk);
         #1;
         cyc++;
         if (o_phase_select != prev_ps) begin
            mark = cyc;
            chg_cyc[o_phase_select] = cyc;
         end
         if (o_busy && !prev_busy) mark = cyc;
         prev_ps   = o_phase_select;
         prev_busy = o_busy;
      end
   end

   // Sequencer model: acks each request after a hold, then returns a word whose value
   // depends on whether the phase is one that reads correctly.
   initial begin
      int ph, hold, hi, dly;
      i_cmd_ack  = 1'b0;
      i_rx_valid = 1'b0;
      i_rx_word  = '0;
      forever begin
         @(negedge i_dataclk);
         if (o_cmd_req) begin
            ph = int'(o_phase_select);
            if (req_count[ph] == 0) gap[ph] = cyc - mark;
            req_count[ph]++;
            hold = (fixed_hold > 0) ? fixed_hold : int'($urandom_range(1, 4));
            hi = 1;
            repeat (hold - 1) begin
               @(negedge i_dataclk);
               if (o_cmd_req) hi++;
               else proto_err++;
            end
            i_cmd_ack = 1'b1;
            @(negedge i_dataclk);
            i_cmd_ack = 1'b0;
            if (o_cmd_req) proto_err++;
            req_hi[ph] = hi;
            hs_cyc[ph] = cyc;
            if (ph != no_rx_phase) begin
               dly = (ph == late_phase) ? 20 : int'($urandom_range(0, 5));
               repeat (dly) @(negedge i_dataclk);
               i_rx_valid = 1'b1;
               if (good_mask[ph] || req_count[ph] != fail_trial[ph]) i_rx_word = EXP;
               else i_rx_word = EXP ^ (16'd1 << $urandom_range(0, 15));
               @(negedge i_dataclk);
               i_rx_valid = 1'b0;
               i_rx_word  = 16'($urandom);
            end
         end
      end
   end

   // Reference: try every (start, length) window, keep the longest fully-set one,
   // earliest start first.
   task automatic ref_best(input logic [NP-1:0] m, output int bp, output bit ok);
      int best_len, best_start;
      bit all;
      best_len = 0;
      best_start = 0;
      for (int s = 0; s < NP; s++) begin
         for (int l = 1; s + l <= NP; l++) begin
            all = 1'b1;
            for (int k = s; k < s + l; k++) if (!m[k]) all = 1'b0;
            if (all && l > best_len) begin
               best_len = l;
               best_start = s;
            end
         end
      end
      ok = (best_len > 0);
      bp = ok ? best_start + (best_len - 1) / 2 : 0;
   endtask

   task automatic launch(input logic [NP-1:0] mask, input int nrx, input int hold_fix,
                         input int late, input bit wr_with_start, input string name);
      good_mask   = mask;
      no_rx_phase = nrx;
      fixed_hold  = hold_fix;
      late_phase  = late;
      for (int p = 0; p < 16; p++) begin
         req_count[p]  = 0;
         gap[p]        = -1;
         hs_cyc[p]     = -1;
         req_hi[p]     = 0;
         fail_trial[p] = int'($urandom_range(1, TR));
      end
      pe0 = proto_err;
      ref_best(mask, exp_bp, exp_ok);
      exp_ps = exp_ok ? exp_bp : int'(o_phase_select);
      i_start = 1'b1;
      if (wr_with_start) begin
         i_phase_wr = 1'b1;
         i_phase_in = 4'd3;
      end
      @(negedge i_dataclk);
      i_start    = 1'b0;
      i_phase_wr = 1'b0;
      n_checks++;
      if (o_busy !== 1'b1 || o_phase_select !== 4'd0) begin
         n_fail++;
         $display("FAIL %s start_accept busy=%b phase=%0d, required busy=1 phase=0", name, o_busy, o_phase_select);
      end
   endtask

   task automatic check_run(input string name);
      int t, bz, extra;
      bit seen;
      logic [NP-1:0] g_map;
      logic [3:0] g_bp, g_ps;
      logic g_ok;
      t = 0; bz = 0; seen = 0; extra = 0;
      g_map = '0; g_bp = '0; g_ps = '0; g_ok = 1'b0;
      while (!seen && t < 8000) begin
         if (o_done) begin
            seen = 1'b1;
            g_map = o_pass_map; g_bp = o_best_phase; g_ok = o_cal_ok; g_ps = o_phase_select;
         end else if (!o_busy) bz++;
         @(negedge i_dataclk);
         t++;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s done_timeout no done within %0d cycles", name, t);
         return;
      end
      n_checks++;
      if (g_map !== good_mask) begin n_fail++; $display("FAIL %s pass_map got %h required %h", name, g_map, good_mask); end
      n_checks++;
      if (g_bp !== 4'(exp_bp)) begin n_fail++; $display("FAIL %s best_phase got %0d required %0d", name, g_bp, exp_bp); end
      n_checks++;
      if (g_ok !== exp_ok) begin n_fail++; $display("FAIL %s cal_ok got %b required %b", name, g_ok, exp_ok); end
      n_checks++;
      if (g_ps !== 4'(exp_ps)) begin n_fail++; $display("FAIL %s phase_select got %0d required %0d", name, g_ps, exp_ps); end
      n_checks++;
      if (bz != 0) begin n_fail++; $display("FAIL %s busy_or_done_low got %0d cycles required 0", name, bz); end
      n_checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL %s after_done done=%b busy=%b required 0 0", name, o_done, o_busy); end
      n_checks++;
      if (proto_err != pe0) begin n_fail++; $display("FAIL %s cmd_req_protocol errors got %0d required 0", name, proto_err - pe0); end
      for (int p = 0; p < NP; p++) begin
         int exp_cnt;
         exp_cnt = good_mask[p] ? TR : ((p == no_rx_phase) ? 1 : fail_trial[p]);
         n_checks++;
         if (req_count[p] != exp_cnt) begin n_fail++; $display("FAIL %s reads_phase%0d got %0d required %0d", name, p, req_count[p], exp_cnt); end
         n_checks++;
         if (gap[p] != SC) begin n_fail++; $display("FAIL %s settle_phase%0d got %0d required %0d", name, p, gap[p], SC); end
      end
      repeat (3) begin
         if (o_done) extra++;
         @(negedge i_dataclk);
      end
      n_checks++;
      if (extra != 0 || o_pass_map !== g_map || o_best_phase !== g_bp || o_cal_ok !== g_ok || o_phase_select !== g_ps) begin
         n_fail++;
         $display("FAIL %s hold extra_done=%0d map=%h bp=%0d ok=%b ps=%0d, required 0 %h %0d %b %0d",
                  name, extra, o_pass_map, o_best_phase, o_cal_ok, o_phase_select, g_map, g_bp, g_ok, g_ps);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge i_dataclk);
      n_checks++; if (o_phase_select !== 4'd0) begin n_fail++; $display("FAIL reset phase_select got %0d required 0", o_phase_select); end
      n_checks++; if (o_cmd_req !== 1'b0) begin n_fail++; $display("FAIL reset cmd_req got %b required 0", o_cmd_req); end
      n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b required 0", o_busy); end
      n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b required 0", o_done); end
      n_checks++; if (o_pass_map !== '0) begin n_fail++; $display("FAIL reset pass_map got %h required 0", o_pass_map); end
      n_checks++; if (o_best_phase !== 4'd0) begin n_fail++; $display("FAIL reset best_phase got %0d required 0", o_best_phase); end
      n_checks++; if (o_cal_ok !== 1'b0) begin n_fail++; $display("FAIL reset cal_ok got %b required 0", o_cal_ok); end
      i_reset = 1'b0;
      @(negedge i_dataclk);
   endtask

   task automatic test_phase_write();
      int v, e;
      i_phase_wr = 1'b1; i_phase_in = 4'd14;
      @(negedge i_dataclk);
      i_phase_wr = 1'b0;
      n_checks++;
      if (o_phase_select !== 4'd11) begin n_fail++; $display("FAIL phase_wr_clamp got %0d required 11", o_phase_select); end
      for (int i = 0; i < 4; i++) begin
         v = int'($urandom_range(0, 15));
         e = (v > NP - 1) ? NP - 1 : v;
         i_phase_wr = 1'b1; i_phase_in = 4'(v);
         @(negedge i_dataclk);
         i_phase_wr = 1'b0;
         n_checks++;
         if (o_phase_select !== 4'(e)) begin n_fail++; $display("FAIL phase_wr_%0d got %0d required %0d", v, o_phase_select, e); end
      end
   endtask

   task automatic test_directed_sweep();
      launch(12'h0F8, -1, 0, -1, 1'b0, "sweep_3to7");
      check_run("sweep_3to7");
   endtask

   task automatic test_tie();
      launch(12'h306, -1, 0, -1, 1'b0, "tie");
      check_run("tie");
   endtask

   task automatic test_no_pass();
      i_phase_wr = 1'b1; i_phase_in = 4'd9;
      @(negedge i_dataclk);
      i_phase_wr = 1'b0;
      n_checks++;
      if (o_phase_select !== 4'd9) begin n_fail++; $display("FAIL no_pass preload got %0d required 9", o_phase_select); end
      launch('0, -1, 0, -1, 1'b1, "no_pass");
      check_run("no_pass");
   endtask

   task automatic test_timeout();
      logic [NP-1:0] m;
      m = NP'($urandom) & ~NP'(3);
      launch(m, 0, 5, -1, 1'b0, "timeout");
      check_run("timeout");
      n_checks++;
      if (req_hi[0] != 5) begin n_fail++; $display("FAIL timeout cmd_req_hold got %0d required 5", req_hi[0]); end
      n_checks++;
      if (chg_cyc[1] - hs_cyc[0] != TO + 1) begin
         n_fail++; $display("FAIL timeout wait_to_phase1 got %0d required %0d", chg_cyc[1] - hs_cyc[0], TO + 1);
      end
   endtask

   task automatic test_busy_ignore();
      launch(NP'($urandom), -1, 0, -1, 1'b0, "busy_ignore");
      repeat (2) @(negedge i_dataclk);
      i_start = 1'b1; i_phase_wr = 1'b1; i_phase_in = 4'd7;
      @(negedge i_dataclk);
      i_start = 1'b0; i_phase_wr = 1'b0;
      n_checks++;
      if (o_phase_select !== 4'd0 || o_busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_ignore phase_wr phase=%0d busy=%b required 0 1", o_phase_select, o_busy);
      end
      check_run("busy_ignore");
   endtask

   task automatic test_random();
      logic [NP-1:0] m;
      for (int i = 0; i < 6; i++) begin
         m = (i % 2 == 0) ? NP'($urandom) : NP'($urandom & $urandom);
         launch(m, -1, 0, -1, 1'($urandom), "random");
         check_run("random");
      end
   endtask

   task automatic test_reset_mid();
      int t;
      launch(NP'($urandom), -1, 0, 6, 1'b0, "reset_mid");
      t = 0;
      while (hs_cyc[6] < 0 && t < 4000) begin
         @(negedge i_dataclk);
         t++;
      end
      n_checks++;
      if (hs_cyc[6] < 0) begin n_fail++; $display("FAIL reset_mid reach_phase6 got none in %0d cycles required handshake", t); end
      repeat (3) @(negedge i_dataclk);
      n_checks++;
      if (o_phase_select !== 4'd6 || o_cmd_req !== 1'b0 || o_busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid in_wait phase=%0d req=%b busy=%b required 6 0 1", o_phase_select, o_cmd_req, o_busy);
      end
      i_reset = 1'b1;
      @(negedge i_dataclk);
      i_reset = 1'b0;
      n_checks++;
      if ({o_phase_select, o_cmd_req, o_busy, o_done, o_pass_map, o_best_phase, o_cal_ok} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid outputs ps=%0d req=%b busy=%b done=%b map=%h bp=%0d ok=%b required all 0",
                  o_phase_select, o_cmd_req, o_busy, o_done, o_pass_map, o_best_phase, o_cal_ok);
      end
      repeat (25) @(negedge i_dataclk);
      n_checks++;
      if (o_busy !== 1'b0 || o_cmd_req !== 1'b0 || o_pass_map !== '0 || o_phase_select !== 4'd0) begin
         n_fail++; $display("FAIL reset_mid stray_rx busy=%b req=%b map=%h ps=%0d required 0 0 0 0", o_busy, o_cmd_req, o_pass_map, o_phase_select);
      end
      launch(NP'($urandom), -1, 0, -1, 1'b0, "reset_resweep");
      check_run("reset_resweep");
   endtask

   initial begin
      i_reset    = 1'b1;
      i_start    = 1'b0;
      i_phase_wr = 1'b0;
      i_phase_in = '0;
      test_reset();
      test_phase_write();
      test_directed_sweep();
      test_tie();
      test_no_pass();
      test_timeout();
      test_busy_ignore();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/miso_phase_calibrator.md
MISO_PHASE_CALIBRATOR -- requirements
Module: miso_phase_calibrator

Interface
REQ-001 Parameter NUM_PHASES, 12, number of phase lags swept (0..NUM_PHASES-1).
REQ-002 Parameter TRIALS, 4, reads per phase; all must match for the phase to pass.
REQ-003 Parameter EXPECTED_WORD, 16'h0049, word a correctly-phased read returns.
REQ-004 Parameter SETTLE_CYCLES, 8, idle cycles after each phase_select change before a request.
REQ-005 Parameter TIMEOUT_CYCLES, 255, cycles waited for rx_valid before a trial fails.
REQ-006 dataclk  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 start  in  1  single-cycle pulse; begins calibration.
REQ-009 phase_wr  in  1  manual phase write strobe.
REQ-010 phase_in  in  4  manual phase value.
REQ-011 cmd_req  out  1  request to the SPI sequencer for one read transaction.
REQ-012 cmd_ack  in  1  sequencer accepts; transfer occurs when cmd_req && cmd_ack.
REQ-013 rx_valid  in  1  one-cycle strobe; rx_word holds the phase-selected MISO word.
REQ-014 rx_word  in  16  MISO word from the phase selector.
REQ-015 phase_select  out  4  phase lag driving the MISO phase selector.
REQ-016 busy  out  1  high from the cycle after start acceptance until done.
REQ-017 done  out  1  one-cycle pulse at calibration end.
REQ-018 pass_map  out  NUM_PHASES  bit p set if phase p passed all trials.
REQ-019 best_phase  out  4  chosen phase.
REQ-020 cal_ok  out  1  high if at least one phase passed in the last calibration.

Function
REQ-021 States SHALL be IDLE, SETTLE, REQ, WAIT, EVAL, SEARCH, FINISH.
REQ-022 IDLE: start SHALL save phase_select, clear pass_map, set phase_select=0, trial count=0, enter SETTLE; start outside IDLE SHALL be ignored.
REQ-023 IDLE: phase_wr SHALL load phase_select=min(phase_in, NUM_PHASES-1); phase_wr outside IDLE ignored; start and phase_wr together in IDLE: start wins.
REQ-024 SETTLE: count SETTLE_CYCLES cycles, then enter REQ.
REQ-025 REQ: cmd_req SHALL be high and held until the cmd_ack cycle; cmd_req SHALL drop the cycle after the handshake; enter WAIT.
REQ-026 WAIT: rx_valid SHALL record match = (rx_word == EXPECTED_WORD); TIMEOUT_CYCLES cycles without rx_valid SHALL record match=0; rx_valid outside WAIT ignored.
REQ-027 EVAL: a mismatch SHALL fail the phase immediately (remaining trials skipped); else increment trial count; if trials < TRIALS, enter SETTLE-free REQ; if TRIALS reached, set pass_map[phase].
REQ-028 Phase completion: if phase < NUM_PHASES-1, increment phase_select, reset trial count, enter SETTLE; else enter SEARCH.
REQ-029 SEARCH: scan pass_map index 0..NUM_PHASES-1, one bit per cycle (NUM_PHASES cycles), tracking the longest contiguous run of set bits; no wrap-around from last to first phase.
REQ-030 Ties SHALL select the run with the lowest start index.
REQ-031 best_phase SHALL equal run_start + (run_len-1)/2 (integer floor).
REQ-032 FINISH: if a run exists, cal_ok=1, phase_select=best_phase; else cal_ok=0, best_phase=0, phase_select=saved value; done pulses this cycle; return to IDLE.
REQ-033 busy SHALL be low in IDLE and high in every other state; done and busy SHALL never both be low while state != IDLE.
REQ-034 pass_map, best_phase, cal_ok SHALL hold until the next accepted start.
REQ-035 Counters SHALL be sized to hold their parameter maxima without wrap.

Reset
REQ-036 reset SHALL force IDLE; phase_select=0, cmd_req=0, busy=0, done=0, pass_map=0, best_phase=0, cal_ok=0, all counters 0.
REQ-037 reset mid-calibration SHALL abort with the REQ-036 values the next cycle; outstanding cmd_ack/rx_valid after reset SHALL be ignored.

Verification
REQ-038 Model returns 16'h0049 only for phases 3..7 -> pass_map=12'h0F8, best_phase=5, cal_ok=1, phase_select=5, one done pulse.
REQ-039 Passing phases {1,2} and {8,9} -> tie, best_phase=1, phase_select=1.
REQ-040 No phase passes, phase_select=9 before start -> pass_map=0, cal_ok=0, best_phase=0, phase_select=9.
REQ-041 cmd_ack delayed 5 cycles and rx_valid never returned at phase 0 -> cmd_req held 5 cycles, phase 0 fails after 255-cycle timeout, sweep continues to phase 1.
REQ-042 phase_wr with phase_in=14 in IDLE -> phase_select=11; phase_wr during busy -> no change; start during busy -> ignored.
REQ-043 reset asserted in WAIT at phase 6 -> next cycle all outputs at REQ-036 values; subsequent start runs a full clean sweep.
